// File: rtl/coef_loader_pkg.sv
// Shared types for the coefficient loader: FSM state encoding and statistics counter width.
package coef_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DROP   = 2'd2,
    COMMIT = 2'd3
  } loader_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/coef_shadow_bank.sv
// Write-indexed shadow register array. A single copy strobe transfers the whole
// shadow into the active bank so consumers only ever see complete coefficient sets.
module coef_shadow_bank #(
  parameter int COEFW = 18,
  parameter int NCOEF = 6,
  parameter int IDXW  = $clog2(NCOEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDXW-1:0]  widx,
  input  logic [COEFW-1:0] wdata,
  input  logic             copy,
  output logic [COEFW-1:0] c [NCOEF]
);

  logic [COEFW-1:0] shadow [NCOEF];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) begin
        shadow[i] <= '0;
        c[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < NCOEF; i++) begin
        if (we && (widx == IDXW'(i))) begin
          shadow[i] <= wdata;
        end
        // Bulk commit: every active entry updates on the same edge.
        if (copy) begin
          c[i] <= shadow[i];
        end
      end
    end
  end

endmodule

// File: rtl/coef_loader.sv
// Stream-to-parallel coefficient loader with atomic bank commit and length checking.
// Optional statistics outputs n_commits/n_errors are enabled by `COEF_LOADER_STATS_EN.
module coef_loader
  import coef_loader_pkg::*;
#(
  parameter  int COEFW = 18,
  parameter  int NCOEF = 6,
  localparam int IDXW  = $clog2(NCOEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COEFW-1:0]  s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [COEFW-1:0]  c [NCOEF],
  output logic              c_update,
  output logic              err
`ifdef COEF_LOADER_STATS_EN
  ,
  output logic [STAT_W-1:0] n_commits,
  output logic [STAT_W-1:0] n_errors
`endif
);

  loader_state_t   state, state_nxt;
  logic [IDXW-1:0] idx, idx_nxt;
  logic            err_nxt, upd_nxt;
  logic            we, copy, xfer, last_idx;

  // Ready depends only on state (and reset), never on s_tvalid.
  assign s_tready = !rst && (state != COMMIT);
  assign xfer     = s_tvalid && s_tready;
  assign last_idx = (idx == IDXW'(NCOEF - 1));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_nxt   = 1'b0;
    upd_nxt   = 1'b0;
    we        = 1'b0;
    copy      = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          we = 1'b1;
          if (s_tlast) begin
            err_nxt = 1'b1;
            idx_nxt = '0;
          end else begin
            idx_nxt   = IDXW'(1);
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          we = 1'b1;
          if (s_tlast) begin
            idx_nxt = '0;
            if (last_idx) begin
              state_nxt = COMMIT;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end
          end else if (last_idx) begin
            idx_nxt   = '0;
            state_nxt = DROP;
          end else begin
            idx_nxt = idx + IDXW'(1);
          end
        end
      end
      DROP: begin
        // Overlong load: swallow words until the terminating tlast.
        if (xfer && s_tlast) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      COMMIT: begin
        copy      = 1'b1;
        upd_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      c_update <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      c_update <= upd_nxt;
      err      <= err_nxt;
    end
  end

  coef_shadow_bank #(
    .COEFW (COEFW),
    .NCOEF (NCOEF),
    .IDXW  (IDXW)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .widx  (idx),
    .wdata (s_tdata),
    .copy  (copy),
    .c     (c)
  );

`ifdef COEF_LOADER_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_commits <= '0;
      n_errors  <= '0;
    end else begin
      if (c_update) n_commits <= sat_inc(n_commits);
      if (err)      n_errors  <= sat_inc(n_errors);
    end
  end
`endif

endmodule

// File: tb/tb_coef_loader.sv
// Scoreboard bench for coef_loader: a driver issues word streams, a negedge monitor
// checks pulses, ready and the active bank against a load-length reference model.
module tb_coef_loader;

  localparam int COEFW = 18;
  localparam int NCOEF = 6;
  localparam int W     = COEFW * NCOEF;

  logic             clk;
  logic             rst;
  logic [COEFW-1:0] s_tdata;
  logic             s_tvalid;
  logic             s_tlast;
  logic             s_tready;
  logic [COEFW-1:0] c [NCOEF];
  logic             c_update;
  logic             err;
`ifdef COEF_LOADER_STATS_EN
  logic [15:0]      n_commits;
  logic [15:0]      n_errors;
`endif

  coef_loader #(.COEFW(COEFW), .NCOEF(NCOEF)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .c        (c),
    .c_update (c_update),
    .err      (err)
`ifdef COEF_LOADER_STATS_EN
    ,
    .n_commits(n_commits),
    .n_errors (n_errors)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         due;
    bit         commit;
    logic [W-1:0] vals;
  } ev_t;

  ev_t              evq[$];
  logic [COEFW-1:0] cur[$];
  logic [W-1:0]     exp_c = '0;
  int               cyc = 0;
  int               stall_at = -1;
  int               m_commits = 0;
  int               m_errors = 0;

  function automatic logic [W-1:0] pack_c();
    logic [W-1:0] p;
    for (int i = 0; i < NCOEF; i++) p[i*COEFW +: COEFW] = c[i];
    return p;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor / reference model: a load commits iff exactly NCOEF words arrive up to tlast.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_tready", W'(s_tready), '0);
      chk("rst_c_update", W'(c_update), '0);
      chk("rst_err", W'(err), '0);
      chk("rst_c", pack_c(), '0);
`ifdef COEF_LOADER_STATS_EN
      chk("rst_n_commits", W'(n_commits), '0);
      chk("rst_n_errors", W'(n_errors), '0);
`endif
      cur.delete();
      evq.delete();
      exp_c     = '0;
      stall_at  = -1;
      m_commits = 0;
      m_errors  = 0;
    end else begin
`ifdef COEF_LOADER_STATS_EN
      chk("n_commits", W'(n_commits), W'(m_commits));
      chk("n_errors", W'(n_errors), W'(m_errors));
`endif
      chk("tready", W'(s_tready), W'(cyc != stall_at));
      if (evq.size() > 0 && evq[0].due == cyc) begin
        ev_t ev;
        ev = evq.pop_front();
        if (ev.commit) begin
          chk("c_update_pulse", W'(c_update), W'(1));
          chk("err_quiet_on_commit", W'(err), '0);
          exp_c = ev.vals;
          m_commits++;
        end else begin
          chk("err_pulse", W'(err), W'(1));
          chk("c_update_quiet_on_err", W'(c_update), '0);
          m_errors++;
        end
      end else begin
        chk("c_update_idle", W'(c_update), '0);
        chk("err_idle", W'(err), '0);
      end
      chk("c_bank", pack_c(), exp_c);
      if (s_tvalid && s_tready) begin
        cur.push_back(s_tdata);
        if (s_tlast) begin
          ev_t ne;
          ne.vals = '0;
          if (cur.size() == NCOEF) begin
            for (int i = 0; i < NCOEF; i++) ne.vals[i*COEFW +: COEFW] = cur[i];
            ne.commit = 1'b1;
            ne.due    = cyc + 2;
            stall_at  = cyc + 1;
          end else begin
            ne.commit = 1'b0;
            ne.due    = cyc + 1;
          end
          evq.push_back(ne);
          cur.delete();
        end
      end
    end
  end

  task automatic send(input logic [COEFW-1:0] d, input bit last, input int gap);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      s_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got s_tready=0 for 8 cycles expected 1");
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_load(input int len, input int base, input bit gapped);
    for (int w = 0; w < len; w++)
      send(COEFW'(base + w), (w == len - 1), (gapped && w > 0) ? 1 : 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("async_rst_c", pack_c(), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [COEFW-1:0] gvals [NCOEF];
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    send_load(NCOEF, 1, 1'b0);          // nominal 1..6
    send_load(4, 7, 1'b0);              // short
    send_load(NCOEF + 2, 20, 1'b0);     // long
    send_load(1, 40, 1'b0);             // length one
    gvals = '{18'h3FFFF, 18'h0, 18'h20000, 18'h1, 18'h2, 18'h3};
    for (int w = 0; w < NCOEF; w++)     // gapped valid, extreme values
      send(gvals[w], (w == NCOEF - 1), (w > 0) ? 1 : 0);
    repeat (3) @(posedge clk); #1;

    send_load(3, 50, 1'b0);             // reset mid-load
    pulse_reset();
    send_load(NCOEF, 60, 1'b0);
    send_load(NCOEF, 70, 1'b0);         // reset during COMMIT
    pulse_reset();
    send_load(NCOEF, 80, 1'b1);

    for (int n = 0; n < 40; n++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NCOEF + 3) : NCOEF;
      for (int w = 0; w < len; w++) begin
        logic [COEFW-1:0] d;
        d = COEFW'($urandom());
        send(d, (w == len - 1), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0);
      end
    end

    for (int k = 0; k < 20 && evq.size() > 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("pending_events", W'(evq.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coef_loader.md
Name: coef_loader

Overview:
- Writer side of the parallel coefficient-array interface used by the filter models: `c[N]` of width `COEFW`, sampled by the model every cycle.
- Accepts coefficients one word at a time on a valid/ready stream.
- Collects them into a shadow bank and commits the whole bank atomically to the registered output array.
- Consumers therefore never see a partially updated coefficient set.

Parameters:
- COEFW, 18, coefficient word width in bits.
- NCOEF, 6, number of coefficients per bank (>= 2).
- IDXW, $clog2(NCOEF), width of the internal write-index counter (derived, not overridden).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_tdata  input  COEFW  coefficient word.
- s_tvalid  input  1  word valid.
- s_tlast  input  1  marks final word of a bank load.
- s_tready  output  1  loader can accept a word.
- c  output  COEFW x NCOEF (unpacked array `[NCOEF]`)  active coefficient bank.
- c_update  output  1  one-cycle pulse in the first cycle new `c` values are visible.
- err  output  1  one-cycle pulse on a malformed load (wrong length).

Behaviour:
- Transfer rule: a word transfers on a rising edge where `s_tvalid && s_tready`. `s_tdata` and `s_tlast` are sampled only on a transfer.
- Reset (async assert, sync release):
  - state=IDLE, index=0.
  - All `c[i]` = 0 and all shadow entries = 0.
  - `c_update` = 0, `err` = 0, `s_tready` = 0 while `rst` is high.
- States: IDLE, LOAD, DROP, COMMIT.
- IDLE:
  - `s_tready` = 1.
  - First transfer writes shadow[0], index <= 1, goes to LOAD.
  - If that word has `s_tlast`=1 (length 1): `err` pulses next cycle, state stays IDLE, index=0.
- LOAD:
  - `s_tready` = 1.
  - Each transfer writes shadow[index] and increments index.
  - Transfer with `s_tlast`=1 and index==NCOEF-1: go to COMMIT.
  - Transfer with `s_tlast`=1 and index<NCOEF-1 (short): `err` pulses next cycle, go to IDLE, index=0. Shadow contents are don't-care; active `c` is unchanged.
  - Transfer with `s_tlast`=0 and index==NCOEF-1 (long): go to DROP.
- DROP:
  - `s_tready` = 1; words are discarded.
  - A transfer with `s_tlast`=1 pulses `err` next cycle and returns to IDLE.
  - Active `c` is unchanged.
- COMMIT:
  - Exactly one cycle, with `s_tready` = 0.
  - At the end of this cycle `c <= shadow` (all NCOEF at once) and `c_update <= 1`.
  - Next state is IDLE.
- Latency: final word transferred on edge N means:
  - `s_tready` is low during cycle N+1.
  - New `c` and `c_update`=1 appear in cycle N+2.
  - The next load word can transfer on edge N+2.
- Pulse width: `c_update` and `err` are registered and high for exactly one cycle. They are never high simultaneously.
- `s_tready` is combinational from state only, never from `s_tvalid`. `s_tvalid` low in any state means no change.
- Reset mid-load or mid-COMMIT: the load is abandoned and `c` is forced to 0. No `c_update` or `err` is issued.
- Words are stored bit-exact; no sign extension or arithmetic.

Optional Feature:
- Macro: `COEF_LOADER_STATS_EN`.
- When defined, two extra outputs are added:
  - `n_commits` [15:0]: increments on every `c_update` pulse.
  - `n_errors` [15:0]: increments on every `err` pulse.
- Both counters saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package `coef_loader_pkg`:
  - typedef enum `loader_state_t` {IDLE, LOAD, DROP, COMMIT}.
  - localparam `STAT_W` = 16.
- Sub-module: `coef_shadow_bank`, a write-indexed NCOEF x COEFW register array with a bulk `copy` strobe that drives the active array; instantiated once.
- The FSM and index counter stay in `coef_loader`.

Test Plan:
- Nominal load: NCOEF=6, 6 back-to-back words 1..6, tlast on the 6th -> `s_tready` low one cycle; `c`={1,2,3,4,5,6} and `c_update`=1 two cycles after the last transfer; `err`=0.
- Short load: 4 words 7..10, tlast on the 4th after a nominal load -> `err` pulse one cycle; `c` stays {1..6}; no `c_update`.
- Long load: 8 words, tlast on the 8th -> words 7–8 accepted (`s_tready`=1); `err` pulses once after the 8th; `c` unchanged.
- Gapped valid: 6 words 'h3FFFF,0,'h20000,1,2,3 with `s_tvalid` toggling every cycle -> `c` holds the exact 18-bit values; one `c_update`.
- Reset mid-load: assert `rst` after 3 of 6 words -> `c` all 0 immediately (async); next complete 6-word load commits normally.
- With `COEF_LOADER_STATS_EN`: 2 good loads plus 1 short load -> `n_commits`=2, `n_errors`=1; reset clears both to 0.
